pcie_tx_merge: RTL

Transmit-side merger for the PCIE link: four class queues (VC0–VC3) are arbitrated round-robin into one 12-bit output stream. Each word leaves with its source class written into bits [11:10], so the receive-side demux can route it back to data_out4..7. A threshold register gives backpressure, and optional per-class word counters are read through the req/idx port.

---
 rtl/pcie_tx_merge.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pcie_tx_merge.sv
// PCIe TX merger: four class FIFOs, round-robin into one tagged output FIFO.
// Optional per-class grant counters are built when PCIE_TX_COUNTERS_EN is defined.
module pcie_tx_merge #(
  parameter int TAMANO_DATOS = 12,
  parameter int UMBRALES_L_H = 8,
  parameter int IN_DEPTH     = 4,
  parameter int OUT_DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              push_in,
  input  logic [TAMANO_DATOS-1:0] data_in0,
  input  logic [TAMANO_DATOS-1:0] data_in1,
  input  logic [TAMANO_DATOS-1:0] data_in2,
  input  logic [TAMANO_DATOS-1:0] data_in3,
  input  logic                    pop_out,
  input  logic [UMBRALES_L_H-1:0] umbral_LH,
  input  logic                    req,
  input  logic [2:0]              idx,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [3:0]              full_in,
  output logic [3:0]              err_ovf,
  output logic [4:0]              cnt_out,
  output logic                    cnt_valid
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = IAW + 1;
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = OAW + 1;
  localparam int HW  = UMBRALES_L_H / 2;
  localparam int CW  = (OCW > HW) ? OCW : HW;

  logic [TAMANO_DATOS-1:0] r_imem [4][IN_DEPTH];
  logic [IAW-1:0]          r_iwp  [4];
  logic [IAW-1:0]          r_irp  [4];
  logic [ICW-1:0]          r_icnt [4];
  logic [3:0]              r_err;
  logic [1:0]              r_last;

  logic [TAMANO_DATOS-1:0] r_omem [OUT_DEPTH];
  logic [OAW-1:0]          r_owp;
  logic [OAW-1:0]          r_orp;
  logic [OCW-1:0]          r_ocnt;
  logic [TAMANO_DATOS-1:0] r_dout;
  logic                    r_vout;
  logic                    r_af;
  logic                    r_ae;

  logic [TAMANO_DATOS-1:0] w_din [4];
  logic [3:0]              w_ne;
  logic [3:0]              w_full;
  logic [3:0]              w_ipush;
  logic [3:0]              w_ipop;
  logic [1:0]              w_gnt;
  logic [1:0]              w_c;
  logic                    w_any;
  logic                    w_xfer;
  logic                    w_opop;
  logic [OCW-1:0]          w_ocnt_nxt;
  logic [TAMANO_DATOS-1:0] w_ihead;
  logic [TAMANO_DATOS-1:0] w_gword;
  logic [HW-1:0]           w_af_fld;
  logic [HW-1:0]           w_ae_fld;
  logic [CW-1:0]           w_af;
  logic                    w_unused;

  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_din[2] = data_in2;
  assign w_din[3] = data_in3;

  assign w_af_fld = umbral_LH[UMBRALES_L_H-1:HW];
  assign w_ae_fld = umbral_LH[HW-1:0];
  // Out-of-range almost-full levels fall back to the full depth.
  assign w_af = (w_af_fld == '0 || CW'(w_af_fld) > CW'(OUT_DEPTH))
              ? CW'(OUT_DEPTH) : CW'(w_af_fld);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_ne[i]   = (r_icnt[i] != '0);
      w_full[i] = (r_icnt[i] == ICW'(IN_DEPTH));
    end
  end

  always_comb begin
    w_any = 1'b0;
    w_gnt = 2'd0;
    w_c   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_c = r_last + 2'(k);
      if (!w_any && w_ne[w_c]) begin
        w_any = 1'b1;
        w_gnt = w_c;
      end
    end
  end

  assign w_xfer  = w_any && (CW'(r_ocnt) < w_af);
  assign w_ihead = r_imem[w_gnt][r_irp[w_gnt]];
  assign w_gword = {w_gnt, w_ihead[TAMANO_DATOS-3:0]};
  assign w_opop  = pop_out && (r_ocnt != '0);

  // A full FIFO still accepts a push when the arbiter drains it this cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_ipop[i]  = w_xfer && (w_gnt == 2'(i));
      w_ipush[i] = push_in[i] && (!w_full[i] || w_ipop[i]);
    end
  end

  always_comb begin
    w_ocnt_nxt = r_ocnt;
    if (w_xfer && !w_opop)
      w_ocnt_nxt = r_ocnt + OCW'(1);
    else if (!w_xfer && w_opop)
      w_ocnt_nxt = r_ocnt - OCW'(1);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_ipush[i])
        r_imem[i][r_iwp[i]] <= w_din[i];
    if (w_xfer)
      r_omem[r_owp] <= w_gword;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_iwp[i]  <= '0;
        r_irp[i]  <= '0;
        r_icnt[i] <= '0;
      end
      r_err  <= '0;
      r_last <= 2'd3;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_ipush[i])
          r_iwp[i] <= r_iwp[i] + IAW'(1);
        if (w_ipop[i])
          r_irp[i] <= r_irp[i] + IAW'(1);
        if (w_ipush[i] && !w_ipop[i])
          r_icnt[i] <= r_icnt[i] + ICW'(1);
        else if (!w_ipush[i] && w_ipop[i])
          r_icnt[i] <= r_icnt[i] - ICW'(1);
        if (push_in[i] && !w_ipush[i])
          r_err[i] <= 1'b1;
      end
      if (w_xfer)
        r_last <= w_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owp  <= '0;
      r_orp  <= '0;
      r_ocnt <= '0;
      r_dout <= '0;
      r_vout <= 1'b0;
      r_af   <= 1'b0;
      r_ae   <= 1'b1;
    end else begin
      if (w_xfer)
        r_owp <= r_owp + OAW'(1);
      if (w_opop) begin
        r_orp  <= r_orp + OAW'(1);
        r_dout <= r_omem[r_orp];
      end
      r_vout <= w_opop;
      r_ocnt <= w_ocnt_nxt;
      r_af   <= (CW'(w_ocnt_nxt) >= w_af);
      r_ae   <= (CW'(w_ocnt_nxt) <= CW'(w_ae_fld));
    end
  end

  assign data_out     = r_dout;
  assign valid_out    = r_vout;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign full_in      = w_full;
  assign err_ovf      = r_err;

`ifdef PCIE_TX_COUNTERS_EN
  logic [4:0] r_vc_cnt [4];
  logic [4:0] r_cnt_out;
  logic       r_cnt_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++)
        r_vc_cnt[i] <= '0;
      r_cnt_out   <= '0;
      r_cnt_valid <= 1'b0;
    end else begin
      if (w_xfer)
        r_vc_cnt[w_gnt] <= r_vc_cnt[w_gnt] + 5'd1;
      r_cnt_valid <= req;
      if (req)
        r_cnt_out <= idx[2] ? 5'd0 : r_vc_cnt[idx[1:0]];
    end
  end

  assign cnt_out   = r_cnt_out;
  assign cnt_valid = r_cnt_valid;
  assign w_unused  = ^w_ihead[TAMANO_DATOS-1 -: 2];
`else
  assign cnt_out   = '0;
  assign cnt_valid = 1'b0;
  assign w_unused  = ^{w_ihead[TAMANO_DATOS-1 -: 2], req, idx};
`endif

endmodule
